toggle_sched: RTL and testbench
===============================

TOGGLE_SCHED -- requirements
Module: toggle_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the transition-count resource.
REQ-002 Parameter DATA_W, default 16: per-requester serial word width.
REQ-003 Parameter LEN_W, default 4: per-requester length field width; field value L means L+1 bits.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-006 req  input  NREQ  per-requester request; held high with data/len stable until its gnt bit is seen.
REQ-007 req_data  input  NREQ*DATA_W  flat bus, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_len  input  NREQ*LEN_W  flat bus, requester i at bits [i*LEN_W +: LEN_W].
REQ-009 gnt  output  NREQ  one-hot, high exactly one cycle when the request is accepted.
REQ-010 busy  output  1  high from the grant cycle through the done cycle inclusive.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 done_id  output  log2(NREQ)  index of the requester whose result is on tcount.
REQ-013 tcount  output  LEN_W  number of 0->1 or 1->0 changes between consecutive bits of the accepted word.

Function
REQ-014 States: IDLE, GRANT, SHIFT, REPORT; all outputs are registered.
REQ-015 IDLE: when any req bit is high, select the winner round-robin, latch its data and len, go to GRANT; otherwise stay.
REQ-016 Round-robin: search starts at pointer p (0 after reset); after granting i, p becomes (i+1) mod NREQ.
REQ-017 GRANT: gnt[winner]=1, busy=1, bit counter and tcount cleared, prev-bit register loaded with data bit 0; go to SHIFT.
REQ-018 SHIFT: one bit per cycle, LSB first, bits 1..L; tcount increments when the current bit differs from prev-bit; prev-bit updated every cycle.
REQ-019 SHIFT lasts exactly L cycles; L=0 (1-bit word) skips SHIFT and goes directly to REPORT with tcount=0.
REQ-020 REPORT: done=1, done_id=winner, tcount final for that cycle only; then IDLE.
REQ-021 Latency: req sampled high at edge k gives gnt in cycle k+1, done in cycle k+L+2; the next grant comes no earlier than the cycle after done.
REQ-022 tcount never exceeds DATA_W-1; no saturation logic.
REQ-023 req changes while busy are ignored; a req dropped before its grant is never granted and leaves p unchanged.
REQ-024 Bits above index L of the latched word are ignored.

Reset
REQ-025 rst low forces, asynchronously: state IDLE, p=0, gnt=0, busy=0, done=0, done_id=0, tcount=0.
REQ-026 rst asserted mid-SHIFT or mid-REPORT discards the operation; no done is produced for it.
REQ-027 After rst release, the first edge with req high behaves as REQ-015.

Structure
REQ-028 State encodings and the defaults for NREQ, DATA_W and LEN_W live in a shared package/include, toggle_pkg.
REQ-029 The round-robin selector is a separate sub-module, rr_arbiter (inputs req and p; outputs one-hot winner and valid).
REQ-030 The change counter stays inline in toggle_sched.

Verification
REQ-031 Single req[0], data=16'h0005, len=4'd3 (bits 1,0,1,0) -> gnt=4'b0001 in cycle 1, done in cycle 5, tcount=3, done_id=0.
REQ-032 req=4'b1111 held, reset pointer -> grant order 0,1,2,3,0; each done_id matches the preceding grant.
REQ-033 req[2], data=16'hFFFF, len=4'd15 -> tcount=0, done 17 cycles after the req edge; data=16'h5555, len=4'd15 -> tcount=15.
REQ-034 len=4'd0, any data -> gnt then done on the next cycle, tcount=0.
REQ-035 rst driven low at the 3rd SHIFT cycle -> all outputs 0 immediately, no done; after release, a req[1] is granted with p=0 arbitration.
REQ-036 req[3] raised during busy and dropped before done -> never granted; p unchanged.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle-count scheduler.
package toggle_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first active request at or above pointer p, wrapping.
module rr_arbiter
    import toggle_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] p,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [ID_W-1:0] idx;

    // Walk the requesters starting at p; the first one seen wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ID_W'((int'(p) + i) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_sched.sv
// Shared bit-transition counter serving NREQ requesters in round-robin order.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for any request; arbitrate and latch winner's word
// ST_GRANT  | gnt pulse; load prev-bit with bit 0, prime the shifter
// ST_SHIFT  | one bit per cycle (bits 1..L), count changes vs prev-bit
// ST_REPORT | done pulse with done_id/tcount, then back to idle
module toggle_sched
    import toggle_pkg::*;
#(
    parameter  int NREQ   = NREQ_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LEN_W  = LEN_W_DEF,
    localparam int ID_W   = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [LEN_W-1:0]       tcount
);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [LEN_W-1:0]    tcount_q, tcount_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                prev_q, prev_d;

    logic [NREQ-1:0]     win_oh;
    logic                win_valid;
    logic [ID_W-1:0]     win_idx;
    logic [DATA_W-1:0]   sel_data;
    logic [LEN_W-1:0]    sel_len;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .p      (ptr_q),
        .winner (win_oh),
        .valid  (win_valid)
    );

    // Turn the one-hot winner into an index and mux out its word and length.
    always_comb begin
        win_idx  = '0;
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = ID_W'(i);
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state and registered-output logic. rem is a down-counter of bits
    // still to examine; the word is shifted right so the current bit is sh[0],
    // which also makes bits above L irrelevant.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        tcount_d  = tcount_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        sh_d      = sh_q;
        rem_d     = rem_q;
        prev_d    = prev_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = win_oh;
                    busy_d   = 1'b1;
                    id_d     = win_idx;
                    sh_d     = sel_data;
                    rem_d    = sel_len;
                    tcount_d = '0;
                    ptr_d    = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + ID_W'(1);
                end
            end
            ST_GRANT: begin
                prev_d   = sh_q[0];
                sh_d     = sh_q >> 1;
                tcount_d = '0;
                if (rem_q == '0) begin
                    state_d   = ST_REPORT;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                prev_d = sh_q[0];
                sh_d   = sh_q >> 1;
                rem_d  = rem_q - LEN_W'(1);
                if (sh_q[0] != prev_q) begin
                    tcount_d = tcount_q + LEN_W'(1);
                end
                if (rem_q == LEN_W'(1)) begin
                    state_d   = ST_REPORT;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end
            end
            ST_REPORT: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                tcount_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            tcount_q  <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            sh_q      <= '0;
            rem_q     <= '0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            tcount_q  <= tcount_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            sh_q      <= sh_d;
            rem_q     <= rem_d;
            prev_q    <= prev_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign tcount  = tcount_q;

endmodule

// File: tb/tb_toggle_sched.sv
// Bench for toggle_sched: directed scenarios plus randomized traffic against
// a round-robin / transition-count reference model.
module tb_toggle_sched;

    localparam int NREQ   = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 4;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [1:0]             done_id;
    logic [LEN_W-1:0]       tcount;

    logic [DATA_W-1:0]      dat [NREQ];
    logic [LEN_W-1:0]       len [NREQ];

    int checks = 0;
    int errors = 0;
    int p_m    = 0;
    int w;

    toggle_sched #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_len  (req_len),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .tcount   (tcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack per-requester words onto the flat buses.
    always_comb begin
        req_data = '0;
        req_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = dat[i];
            req_len[i*LEN_W +: LEN_W]    = len[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first requester at or after pointer p, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        int idx;
        for (int i = 0; i < NREQ; i++) begin
            idx = (p + i) % NREQ;
            if (((r >> idx) & NREQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    // Reference: count of neighbouring-bit differences over bits 0..L.
    function automatic int trans(input logic [DATA_W-1:0] d, input int L);
        int n;
        n = 0;
        for (int i = 1; i <= L; i++) begin
            if (d[i] != d[i-1]) n++;
        end
        return n;
    endfunction

    // Called at a negedge while the DUT idles and req is already driven.
    // Walks one full transaction, checking every cycle against the model.
    task automatic run_txn(input bit drop, input bit inject, output int wo);
        int w2, L, exp_t;
        w2    = rr_pick(req, p_m);
        L     = int'(len[w2]);
        exp_t = trans(dat[w2], L);
        @(negedge clk);
        chk("gnt_onehot", 32'(gnt), 32'(1 << w2));
        chk("gnt_busy",   32'(busy), 32'd1);
        chk("gnt_done",   32'(done), 32'd0);
        p_m = (w2 + 1) % NREQ;
        if (drop) req[w2] = 1'b0;
        for (int c = 0; c < L; c++) begin
            if (inject && c == 0) begin
                dat[3] = DATA_W'($urandom);
                len[3] = LEN_W'($urandom);
                req[3] = 1'b1;
            end
            if (inject && c == L - 1) req[3] = 1'b0;
            @(negedge clk);
            chk("shift_gnt",  32'(gnt),  32'd0);
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse",  32'(done),    32'd1);
        chk("done_id",     32'(done_id), 32'(w2));
        chk("tcount",      32'(tcount),  32'(exp_t));
        chk("done_busy",   32'(busy),    32'd1);
        chk("done_gnt",    32'(gnt),     32'd0);
        @(negedge clk);
        chk("after_done",  32'(done), 32'd0);
        chk("after_busy",  32'(busy), 32'd0);
        chk("after_gnt",   32'(gnt),  32'd0);
        wo = w2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = '0;
            len[i] = '0;
        end
        #1;
        chk("rst_gnt",     32'(gnt),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_tcount",  32'(tcount),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p_m = 0;

        // All four held from a reset pointer: grants 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = DATA_W'($urandom);
            len[i] = LEN_W'($urandom_range(0, 5));
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) run_txn(1'b0, 1'b0, w);
        req = '0;

        // Single requester, 4-bit word 1,0,1,0.
        dat[0] = 16'h0005;
        len[0] = 4'd3;
        req    = 4'b0001;
        run_txn(1'b1, 1'b0, w);

        // Full-length words: constant and alternating.
        dat[2] = 16'hFFFF;
        len[2] = 4'd15;
        req    = 4'b0100;
        run_txn(1'b1, 1'b0, w);
        dat[2] = 16'h5555;
        req    = 4'b0100;
        run_txn(1'b1, 1'b0, w);

        // One-bit word goes straight from grant to report.
        dat[1] = DATA_W'($urandom);
        len[1] = 4'd0;
        req    = 4'b0010;
        run_txn(1'b1, 1'b0, w);

        // A request raised and withdrawn while busy is never served.
        dat[0] = DATA_W'($urandom);
        len[0] = 4'd6;
        req    = 4'b0001;
        run_txn(1'b1, 1'b1, w);
        repeat (3) begin
            @(negedge clk);
            chk("ghost_gnt",  32'(gnt),  32'd0);
            chk("ghost_busy", 32'(busy), 32'd0);
        end
        dat[0] = DATA_W'($urandom);
        dat[2] = DATA_W'($urandom);
        len[0] = LEN_W'($urandom);
        len[2] = LEN_W'($urandom);
        req    = 4'b0101;
        run_txn(1'b1, 1'b0, w);
        run_txn(1'b1, 1'b0, w);

        // Randomized traffic; waiting requesters keep their word stable.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    dat[i] = DATA_W'($urandom);
                    len[i] = LEN_W'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                w      = int'($urandom_range(0, NREQ - 1));
                dat[w] = DATA_W'($urandom);
                len[w] = LEN_W'($urandom);
                req[w] = 1'b1;
            end
            run_txn(1'b1, 1'b0, w);
        end
        while (req != '0) run_txn(1'b1, 1'b0, w);

        // Reset in the third shift cycle abandons the operation.
        dat[2] = DATA_W'($urandom);
        len[2] = 4'd10;
        req    = 4'b0100;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'd4);
        req = '0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_gnt0",     32'(gnt),     32'd0);
        chk("abort_busy0",    32'(busy),    32'd0);
        chk("abort_done0",    32'(done),    32'd0);
        chk("abort_done_id0", 32'(done_id), 32'd0);
        chk("abort_tcount0",  32'(tcount),  32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        p_m = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle_done", 32'(done), 32'd0);
        end
        dat[1] = DATA_W'($urandom);
        dat[3] = DATA_W'($urandom);
        len[1] = LEN_W'($urandom);
        len[3] = LEN_W'($urandom);
        req    = 4'b1010;
        run_txn(1'b1, 1'b0, w);
        run_txn(1'b1, 1'b0, w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
